seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Downstream display stage for the traffic-light controller: accepts a binary countdown value over a valid/ready handshake and converts it to BCD sequentially (shift-add-3).
- Drives a multiplexed common-anode 7-segment bank with leading-zero blanking, per-digit decimal point and inter-digit ghost blanking.
- Replaces ad-hoc divide/modulo BCD and fixed 2-digit scanning in display paths.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- SCAN_HZ, 1000: digit-advance rate in Hz. Prescale count = CLK_FREQ/SCAN_HZ, which must be at least 4.
- NUM_DIGITS, 2: number of digits, legal range 1..8.
- VAL_W, 7: binary input width, legal range 1..27.

Ports:
- clk, input, 1: system clock. Rising edge only.
- rst, input, 1: synchronous reset, active-high.
- val_in, input, VAL_W: unsigned value to display.
- val_valid, input, 1: val_in is valid.
- val_ready, output, 1: block can accept a value.
- dp_mask, input, NUM_DIGITS: bit i=1 lights the decimal point of digit i. Sampled live, not latched.
- blank_en, input, 1: 1 enables leading-zero blanking. Sampled live.
- seg_out, output, 8: {dp,g,f,e,d,c,b,a}, active-low.
- seg_sel, output, NUM_DIGITS: digit enables, active-low, at most one low. Bit 0 is the ones digit.
- busy, output, 1: conversion in progress.

Behaviour:
- Reset values: seg_out=8'hFF, seg_sel=all ones, val_ready=0, busy=0. Scan index=0, prescaler=0, display register=0.
- First cycle after reset release: val_ready=1.
- FSM states:
  - IDLE: val_ready=1. On val_valid&&val_ready, capture val_in and go to CONV.
  - CONV: busy=1, val_ready=0. One shift-add-3 iteration per cycle, VAL_W cycles total, then go to COMMIT.
  - COMMIT: one cycle. Write the BCD result and overflow flag to the display register, then return to IDLE.
- Latency: display register updates exactly VAL_W+1 cycles after the accepting edge. The next value can be accepted on the cycle after COMMIT.
- The display register holds the old value throughout CONV, so there are no partial-result glitches.
- val_valid while val_ready=0 is ignored. Upstream must hold it; no value is lost and none is queued.
- Overflow: if the captured value exceeds 10^NUM_DIGITS-1, the overflow flag is set. Every digit then shows '-' (8'hBF, dp still from dp_mask). Latency is unchanged.
- BCD accumulator is 4*NUM_DIGITS bits. Bits shifted out above it only feed the overflow flag, which is computed by a compare at capture.
- Scan timing:
  - The prescaler counts 0..CLK_FREQ/SCAN_HZ-1. The cycle it wraps is the tick.
  - On a tick the scan index advances; NUM_DIGITS-1 wraps to 0.
- Ghost blanking: on the tick cycle and the cycle after, seg_sel=all ones and seg_out=8'hFF. For the remaining cycles, the selected digit is driven.
- Outputs are registered: seg_out and seg_sel change one cycle after the index/prescaler state that produces them.
- Leading-zero blanking: when blank_en=1, digit i>0 is blanked (segments 7'h7F, dp still per dp_mask) if it and every higher digit are zero. Digit 0 is never blanked, so value 0 shows "0".
- Segment codes, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, dp bit added above).
- Mid-operation reset: aborts CONV and clears the display register. All outputs return to reset values on the next edge.
- NUM_DIGITS=1: the index stays 0, but ghost blanking still occurs every tick.

Decomposition:
- seg_pkg holds:
  - the state enum {S_IDLE, S_CONV, S_COMMIT};
  - segment constants SEG_BLANK, SEG_DASH and the 0-9 table;
  - function bcd_to_seg(logic [3:0]) returning 7 bits, with any value >9 giving SEG_BLANK.
- Sub-module bin2bcd_seq (start/done, VAL_W-cycle shift-add-3) is natural. The top module keeps the FSM, scan and output registers.

Test Plan (CLK_FREQ=1000, SCAN_HZ=100, so a tick every 10 cycles; NUM_DIGITS=2, VAL_W=7):
- Reset held 3 cycles, then released -> seg_out=FF, seg_sel=11 during reset. val_ready=1 one cycle after release. Display shows "0": ones digit seg_out=C0, tens blanked with blank_en=1.
- Send 25 -> val_ready=0 for 8 cycles. Display register updates 8 cycles after accept. Scanning shows ones=92 (seg_sel=10), tens=A4 (seg_sel=01).
- Send 5 with blank_en=1 -> ones=92, tens digit seg_out=FF. With blank_en=0 -> tens=C0.
- Send 127 -> both digits BF. Then send 30 -> ones=C0, tens=B0.
- Assert val_valid=1 with val_in=9 continuously during a conversion -> exactly one accept per IDLE entry, no accept while busy=1. dp_mask=01 -> ones seg_out bit7=0.
- Assert rst in the 4th CONV cycle -> next edge gives reset values, no COMMIT, display register=0. Also check seg_sel=11 on each tick cycle and the cycle after, and never more than one seg_sel bit low.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, segment encodings and helpers for the scanned 7-segment display.
package seg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Decimal digit to active-low segments; anything above 9 shows nothing
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // 10^n, used at elaboration time for the overflow threshold
    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per cycle,
// VAL_W steps after start. done is high in the cycle of the final step,
// so bcd_out holds the finished result from the following cycle.
module bin2bcd_seq #(
    parameter int VAL_W      = 7,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin_in,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] shift_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_reg;

    // Add 3 to every BCD nibble that is 5 or more before the shift
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    (bcd_reg[4*gi +: 4] + 4'd3) :
                                     bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Load on start, then shift the binary MSB into the BCD accumulator;
    // bits leaving the top of the accumulator are simply dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else if (start) begin
            shift_reg <= bin_in;
            bcd_reg   <= '0;
            cnt_reg   <= CNT_W'(VAL_W);
        end else if (cnt_reg != '0) begin
            bcd_reg   <= {adj[BCD_W-2:0], shift_reg[VAL_W-1]};
            shift_reg <= shift_reg << 1;
            cnt_reg   <= cnt_reg - 1'b1;
        end
    end

    assign done    = (cnt_reg == CNT_W'(1));
    assign bcd_out = bcd_reg;

endmodule

// File: rtl/seg_scan_display.sv
// Display stage: accepts a binary value, converts it to BCD in the
// background and scans it onto a common-anode multiplexed 7-segment bank.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 2,
    parameter int VAL_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VAL_W-1:0]      val_in,
    input  logic                  val_valid,
    output logic                  val_ready,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_en,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic                  busy
);

    localparam int              PRESCALE = CLK_FREQ / SCAN_HZ;
    localparam int              PRE_W    = $clog2(PRESCALE);
    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              BCD_W    = 4 * NUM_DIGITS;
    localparam logic [31:0]     MAX_VAL  = 32'(pow10(NUM_DIGITS) - 1);

    state_t            state_reg, state_next;
    logic              val_ready_reg, busy_reg;
    logic              ovf_cap_reg;
    logic [BCD_W-1:0]  disp_reg;
    logic              disp_ovf_reg;
    logic              accept, conv_done;
    logic [BCD_W-1:0]  bcd_result;

    logic [PRE_W-1:0]  presc_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              tick, ghost;

    logic [7:0]            seg_out_reg;
    logic [NUM_DIGITS-1:0] seg_sel_reg;
    logic [6:0]            dig_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz;

    assign accept = (state_reg == S_IDLE) && val_valid && val_ready_reg;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .bin_in  (val_in),
        .done    (conv_done),
        .bcd_out (bcd_result)
    );

    // Next-state logic of the accept/convert/commit sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept)    state_next = S_CONV;
            S_CONV:   if (conv_done) state_next = S_COMMIT;
            S_COMMIT:                state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // State, handshake flags and the display register (only written in COMMIT,
    // so the scanned value never shows a half-converted result)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            val_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ovf_cap_reg   <= 1'b0;
            disp_reg      <= '0;
            disp_ovf_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            val_ready_reg <= (state_next == S_IDLE);
            busy_reg      <= (state_next == S_CONV);
            if (accept) begin
                ovf_cap_reg <= (32'(val_in) > MAX_VAL);
            end
            if (state_reg == S_COMMIT) begin
                disp_reg     <= bcd_result;
                disp_ovf_reg <= ovf_cap_reg;
            end
        end
    end

    assign tick  = (presc_reg == PRE_W'(PRESCALE - 1));
    assign ghost = tick || (presc_reg == '0);

    // Scan prescaler and digit index; the index moves on the wrap cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // Per-digit segment pattern: dash on overflow, blank for leading zeros
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_ones
                assign lz[gi] = 1'b0;
            end else begin : g_upper
                assign lz[gi] = (disp_reg[BCD_W-1:4*gi] == '0);
            end
            assign dig_seg[gi] = disp_ovf_reg       ? SEG_DASH  :
                                 (blank_en && lz[gi]) ? SEG_BLANK :
                                 bcd_to_seg(disp_reg[4*gi +: 4]);
        end
    endgenerate

    // Registered drivers; everything dark around each digit change
    always_ff @(posedge clk) begin
        if (rst || ghost) begin
            seg_out_reg <= 8'hFF;
            seg_sel_reg <= '1;
        end else begin
            seg_out_reg <= {~dp_mask[idx_reg], dig_seg[idx_reg]};
            seg_sel_reg <= ~(NUM_DIGITS'(1) << idx_reg);
        end
    end

    assign val_ready = val_ready_reg;
    assign busy      = busy_reg;
    assign seg_out   = seg_out_reg;
    assign seg_sel   = seg_sel_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: 10-cycle scan period, two digits,
// 7-bit values. A monitor checks every scanned cycle against hand values.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] val_in;
    logic       val_valid;
    logic       val_ready;
    logic [1:0] dp_mask;
    logic       blank_en;
    logic [7:0] seg_out;
    logic [1:0] seg_sel;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    seg_scan_display #(
        .CLK_FREQ   (1000),
        .SCAN_HZ    (100),
        .NUM_DIGITS (2),
        .VAL_W      (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .val_in    (val_in),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .dp_mask   (dp_mask),
        .blank_en  (blank_en),
        .seg_out   (seg_out),
        .seg_sel   (seg_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected segment byte for ones (index 0) and tens (index 1)
    logic [7:0] exp_seg [2];
    logic       mon_en = 1'b0;
    logic       started = 1'b0;
    int         acc_count = 0;

    // Scan model: 10-cycle prescaler, digit flips on the wrap cycle. The
    // output registers show the blank pattern for the wrap cycle and the one
    // after it, one cycle late.
    int   presc_m = 0;
    int   idx_m = 0;
    int   idx_q = 0;
    logic ghost_q = 1'b1;

    always @(posedge clk) begin
        ghost_q = rst || (presc_m == 9) || (presc_m == 0);
        idx_q   = idx_m;
        started = 1'b1;
        if (val_valid === 1'b1 && val_ready === 1'b1) acc_count++;
        if (rst) begin
            presc_m = 0;
            idx_m   = 0;
        end else if (presc_m == 9) begin
            presc_m = 0;
            idx_m   = idx_m ^ 1;
        end else begin
            presc_m++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (ghost_q) begin
                check_eq("ghost_sel", seg_sel, 2'b11);
                check_eq("ghost_seg", seg_out, 8'hFF);
            end else if (mon_en) begin
                check_eq("scan_sel", seg_sel, (idx_q == 0) ? 2'b10 : 2'b01);
                check_eq("scan_seg", seg_out, exp_seg[idx_q]);
            end
            check_eq("ready_busy_excl", val_ready & busy, 1'b0);
        end
    end

    task automatic set_exp(input logic [7:0] ones, input logic [7:0] tens);
        exp_seg[0] = ones;
        exp_seg[1] = tens;
    endtask

    // Present one value, count the not-ready cycles until the block is idle
    // again, then step once more so the new display is on the outputs.
    task automatic send(input logic [6:0] v);
        int w;
        int lat;
        logic last_busy;
        w = 0;
        while (val_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        check_eq("send_ready_wait", (w < 50), 1'b1);
        val_in    = v;
        val_valid = 1'b1;
        step();
        val_valid = 1'b0;
        check_eq("accept_busy", busy, 1'b1);
        check_eq("accept_ready_low", val_ready, 1'b0);
        lat = 0;
        last_busy = 1'b1;
        while (val_ready !== 1'b1 && lat < 50) begin
            last_busy = busy;
            lat++;
            step();
        end
        check_eq("ready_low_cycles", lat, 8);
        check_eq("commit_not_busy", last_busy, 1'b0);
        step();
        $display("send value=%0d not_ready_cycles=%0d", v, lat);
    endtask

    initial begin
        int acc0;
        rst       = 1'b1;
        val_in    = '0;
        val_valid = 1'b0;
        dp_mask   = 2'b00;
        blank_en  = 1'b1;
        set_exp(8'hC0, 8'hFF);

        // Reset held three cycles
        repeat (3) begin
            step();
            check_eq("rst_seg", seg_out, 8'hFF);
            check_eq("rst_sel", seg_sel, 2'b11);
            check_eq("rst_ready", val_ready, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
        end
        rst = 1'b0;
        step();
        check_eq("ready_after_release", val_ready, 1'b1);
        mon_en = 1'b1;
        repeat (25) step();
        $display("reset done, display shows 0");

        // 25
        send(7'd25);
        set_exp(8'h92, 8'hA4);
        repeat (25) step();

        // 5 with and without leading-zero blanking
        send(7'd5);
        set_exp(8'h92, 8'hFF);
        repeat (25) step();
        blank_en = 1'b0;
        step();
        set_exp(8'h92, 8'hC0);
        repeat (25) step();
        $display("blank_en=0 shows 05");
        blank_en = 1'b1;
        step();
        set_exp(8'h92, 8'hFF);
        repeat (5) step();

        // Overflow, then a value with a zero ones digit
        send(7'd127);
        set_exp(8'hBF, 8'hBF);
        repeat (25) step();
        send(7'd30);
        set_exp(8'hC0, 8'hB0);
        repeat (25) step();

        // Decimal point on the ones digit
        dp_mask = 2'b01;
        step();
        set_exp(8'h40, 8'hB0);
        repeat (25) step();

        // val_valid held high across several conversions
        mon_en = 1'b0;
        check_eq("hold_start_ready", val_ready, 1'b1);
        acc0      = acc_count;
        val_in    = 7'd9;
        val_valid = 1'b1;
        repeat (27) step();
        val_valid = 1'b0;
        check_eq("hold_accepts", acc_count - acc0, 3);
        $display("held valid, accepts=%0d", acc_count - acc0);
        step();
        step();
        set_exp(8'h10, 8'hFF);
        mon_en = 1'b1;
        repeat (25) step();

        dp_mask = 2'b00;
        step();
        set_exp(8'h90, 8'hFF);
        repeat (5) step();

        // Reset during the fourth conversion cycle
        check_eq("abort_start_ready", val_ready, 1'b1);
        val_in    = 7'd99;
        val_valid = 1'b1;
        step();
        val_valid = 1'b0;
        check_eq("abort_busy", busy, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        check_eq("abort_seg", seg_out, 8'hFF);
        check_eq("abort_sel", seg_sel, 2'b11);
        check_eq("abort_ready", val_ready, 1'b0);
        check_eq("abort_busy_low", busy, 1'b0);
        rst = 1'b0;
        set_exp(8'hC0, 8'hFF);
        repeat (30) step();
        check_eq("abort_ready_back", val_ready, 1'b1);
        $display("mid-conversion reset, display cleared to 0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
